in4_debounce: RTL and testbench



---
 rtl/in4_debounce_pkg.sv | 31 +++
 rtl/in4_debounce_ch.sv | 94 +++++++++
 rtl/in4_debounce.sv | 59 +++++
 tb/tb_in4_debounce.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/in4_debounce_pkg.sv
// -----------------------------------------------------------------------------
// in4_debounce_pkg
//
// Shared constants for the four-channel input conditioner that feeds the
// 4-input OR gate. Channel indices follow the OR-gate input lettering, so
// raw_in[CH_A] / clean[CH_A] belong to gate input a, and so on.
// -----------------------------------------------------------------------------
package in4_debounce_pkg;

  // Number of conditioned channels (OR-gate inputs a..d).
  localparam int NUM_CH = 4;

  // Bit position of each OR-gate input inside raw_in / clean / change.
  localparam int CH_A = 0;
  localparam int CH_B = 1;
  localparam int CH_C = 2;
  localparam int CH_D = 3;

  // Default build: two-flop synchroniser, four-cycle stability window.
  localparam int SYNC_STAGES_DEF   = 2;
  localparam int STABLE_CYCLES_DEF = 4;

  // One bit per channel; used for raw/clean/change vectors.
  typedef logic [NUM_CH-1:0] ch_vec_t;

  // Width of a stability counter that has to hold 0..stable_cycles.
  function automatic int cnt_width(input int stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

endpackage : in4_debounce_pkg

// File: rtl/in4_debounce_ch.sv
// -----------------------------------------------------------------------------
// debounce_ch
//
// One conditioned channel: a SYNC_STAGES-deep synchroniser followed by a
// stability counter. The clean level only moves after the synchronised
// input has differed from it for STABLE_CYCLES consecutive enabled cycles;
// any return to the current clean level restarts the count.
//
// Parameters
//   SYNC_STAGES    synchroniser depth, legal range 2..4
//   STABLE_CYCLES  qualification length in clk cycles, legal range 1..65535
//
// Ports
//   clk     rising-edge clock
//   rst     asynchronous, active-high reset
//   en      1 = qualify; 0 = hold clean and discard any partial count
//   raw     asynchronous raw input
//   clean   debounced level
//   change  registered one-cycle pulse on every clean toggle
// -----------------------------------------------------------------------------
module debounce_ch
  import in4_debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic raw,
  output logic clean,
  output logic change
);

  localparam int CNT_W = cnt_width(STABLE_CYCLES);

  // Count value on which the next mismatching cycle completes qualification
  // (cnt+1 == STABLE_CYCLES). The counter therefore never exceeds this.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ss;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             clean_d;
  logic             change_d;

  assign ss = sync_q[SYNC_STAGES-1];

  // The synchroniser keeps shifting while en=0 so that, on re-enable, ss
  // already reflects the current raw level and only the stability window
  // remains to be served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // NOTE: every signal gets a value before any branch so that no path
  // through this block leaves a signal unassigned and infers a latch.
  always_comb begin
    cnt_d    = '0;
    clean_d  = clean;
    change_d = 1'b0;
    if (en && (ss != clean)) begin
      if (cnt_q == CNT_LAST) begin
        clean_d  = ss;
        change_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order; blocking assignments
  // here would let one register see another's new value in the same edge.
  // The async reset clears the counter too, so no partial count survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      clean  <= 1'b0;
      change <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      clean  <= clean_d;
      change <= change_d;
    end
  end

endmodule : debounce_ch

// File: rtl/in4_debounce.sv
// -----------------------------------------------------------------------------
// in4_debounce
//
// Input-conditioning stage directly upstream of the 4-input OR gate. Each
// raw asynchronous line is synchronised into clk and debounced by an
// independent debounce_ch; the resulting clean levels drive OR inputs a..d,
// so the gate output is glitch-free and clk-aligned.
//
// Parameters
//   SYNC_STAGES    synchroniser depth per channel, legal range 2..4
//   STABLE_CYCLES  stability window in clk cycles, legal range 1..65535
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   en          debounce enable; 0 freezes clean and drops partial counts
//   raw_in      raw inputs; bit0->a, bit1->b, bit2->c, bit3->d
//   clean       debounced levels, bit0..3 to OR gate a..d
//   change      one-cycle pulse per channel when its clean bit toggles
//   any_change  OR of change[3:0], same cycle
//
// Latency: a raw level stable before edge E0 reaches clean on edge
// E0 + SYNC_STAGES + STABLE_CYCLES - 1, with change pulsing alongside.
// -----------------------------------------------------------------------------
module in4_debounce
  import in4_debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_CH-1:0] raw_in,
  output logic [NUM_CH-1:0] clean,
  output logic [NUM_CH-1:0] change,
  output logic              any_change
);

  // Channels are identical and fully independent; several may qualify on
  // the same edge.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_ch #(
      .SYNC_STAGES   (SYNC_STAGES),
      .STABLE_CYCLES (STABLE_CYCLES)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .raw    (raw_in[i]),
      .clean  (clean[i]),
      .change (change[i])
    );
  end

  // change is already registered, so this OR adds no extra cycle.
  assign any_change = |change;

endmodule : in4_debounce

// File: tb/tb_in4_debounce.sv
// -----------------------------------------------------------------------------
// tb_in4_debounce
//
// Directed bench for in4_debounce. dut uses the defaults (SYNC_STAGES=2,
// STABLE_CYCLES=4, six-edge latency); dut2 uses SYNC_STAGES=3,
// STABLE_CYCLES=1 for the parameter corner. Inputs change 1 ns after a
// rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_in4_debounce;
  import in4_debounce_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       en2;
  logic [3:0] raw_in;
  logic [3:0] raw2;
  logic [3:0] clean;
  logic [3:0] change;
  logic [3:0] clean2;
  logic [3:0] change2;
  logic       any_change;
  logic       any_change2;

  always #5 clk = ~clk;

  in4_debounce dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .raw_in     (raw_in),
    .clean      (clean),
    .change     (change),
    .any_change (any_change)
  );

  in4_debounce #(
    .SYNC_STAGES   (3),
    .STABLE_CYCLES (1)
  ) dut2 (
    .clk        (clk),
    .rst        (rst),
    .en         (en2),
    .raw_in     (raw2),
    .clean      (clean2),
    .change     (change2),
    .any_change (any_change2)
  );

  typedef struct {
    logic [3:0] raw;
    logic       en;
    logic [3:0] exp_clean;
    logic [3:0] exp_change;
  } vec_t;

  vec_t vecs[$];

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] r, input logic e,
                      input logic [3:0] c, input logic [3:0] ch);
    vec_t v;
    v.raw        = r;
    v.en         = e;
    v.exp_clean  = c;
    v.exp_change = ch;
    vecs.push_back(v);
  endtask

  // One level step with default parameters: five cycles of no visible
  // change, the update with its pulse on the sixth, pulse gone on the
  // seventh.
  task automatic add_step(input logic [3:0] r, input logic [3:0] old_c,
                          input logic [3:0] new_c, input logic [3:0] pulse);
    for (int i = 0; i < 5; i++) push(r, 1'b1, old_c, 4'b0000);
    push(r, 1'b1, new_c, pulse);
    push(r, 1'b1, new_c, 4'b0000);
  endtask

  initial begin
    int   pulses;
    logic hist [0:32];
    logic exp_c;
    logic prev_c;

    // ---------------- table contents ----------------
    push(4'b0000, 1'b1, 4'b0000, 4'b0000);
    push(4'b0000, 1'b1, 4'b0000, 4'b0000);
    add_step(4'b0010, 4'b0000, 4'b0010, 4'b0010);   // clean step on b
    add_step(4'b0000, 4'b0010, 4'b0000, 4'b0010);   // and back
    add_step(4'b1111, 4'b0000, 4'b1111, 4'b1111);   // all four together
    add_step(4'b0000, 4'b1111, 4'b0000, 4'b1111);   // all four released

    // ---------------- reset state ----------------
    rst    = 1'b0;
    en     = 1'b1;
    en2    = 1'b1;
    raw_in = 4'b0000;
    raw2   = 4'b0000;
    #1 rst = 1'b1;
    #6;
    check("reset_clean", clean, 4'b0000);
    check("reset_change", change, 4'b0000);
    check("reset_any", any_change, 1'b0);
    check("reset_clean2", clean2, 4'b0000);
    #1 rst = 1'b0;
    tick(2);

    // ---------------- table-driven vectors ----------------
    foreach (vecs[i]) begin
      raw_in = vecs[i].raw;
      en     = vecs[i].en;
      tick();
      check($sformatf("vec%0d_clean", i), clean, vecs[i].exp_clean);
      check($sformatf("vec%0d_change", i), change, vecs[i].exp_change);
      check($sformatf("vec%0d_any", i), any_change, |vecs[i].exp_change);
      check($sformatf("vec%0d_or_y", i), |clean, |vecs[i].exp_clean);
    end

    // ---------------- reset mid-count ----------------
    raw_in = 4'b0001;
    tick(3);
    check("midrst_before", clean, 4'b0000);
    #1 rst = 1'b1;
    #1;
    check("midrst_clean", clean, 4'b0000);
    check("midrst_change", change, 4'b0000);
    check("midrst_any", any_change, 1'b0);
    #1 rst = 1'b0;
    // A surviving count would have qualified after 3 more edges; a fresh
    // qualification needs the full 6.
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("midrst_k%0d_clean", k), clean, (k >= 6) ? 4'b0001 : 4'b0000);
      check($sformatf("midrst_k%0d_change", k), change, (k == 6) ? 4'b0001 : 4'b0000);
    end

    raw_in = 4'b0000;
    tick(8);
    check("settle0_clean", clean, 4'b0000);

    // ---------------- bounce on c ----------------
    pulses = 0;
    raw_in = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("bounce_hi%0d", k), clean, 4'b0000);
      if (change[2]) pulses++;
    end
    raw_in = 4'b0000;
    tick();
    check("bounce_lo", clean, 4'b0000);
    if (change[2]) pulses++;
    raw_in = 4'b0100;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("bounce_k%0d_clean", k), clean, (k >= 6) ? 4'b0100 : 4'b0000);
      if (change[2]) pulses++;
    end
    check("bounce_pulses", pulses, 1);

    raw_in = 4'b0000;
    tick(8);
    check("settle1_clean", clean, 4'b0000);

    // ---------------- enable gating ----------------
    en     = 1'b0;
    raw_in = 4'b0100;
    for (int k = 0; k < 20; k++) begin
      tick();
      check($sformatf("en0_k%0d_clean", k), clean, 4'b0000);
      check($sformatf("en0_k%0d_change", k), change, 4'b0000);
    end
    en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("en1_k%0d_clean", k), clean, (k >= 4) ? 4'b0100 : 4'b0000);
      check($sformatf("en1_k%0d_change", k), change, (k == 4) ? 4'b0100 : 4'b0000);
    end
    // Disabled: clean must hold even though raw has dropped.
    en     = 1'b0;
    raw_in = 4'b0000;
    tick(10);
    check("freeze_clean", clean, 4'b0100);
    check("freeze_change", change, 4'b0000);
    en = 1'b1;
    tick(6);
    check("unfreeze_clean", clean, 4'b0000);

    // ---------------- async reset with outputs high ----------------
    raw_in = 4'b1111;
    tick(8);
    check("pre_rst_clean", clean, 4'b1111);
    #1 rst = 1'b1;
    #1;
    check("async_rst_clean", clean, 4'b0000);
    check("async_rst_any", any_change, 1'b0);
    raw_in = 4'b0000;
    #1 rst = 1'b0;
    tick(8);
    check("post_rst_clean", clean, 4'b0000);

    // ---------------- SYNC_STAGES=3, STABLE_CYCLES=1 ----------------
    // Raw set before tick k lands on clean2 at tick k+3 (edge E0+3); every
    // toggle of clean2 carries a change pulse.
    pulses = 0;
    prev_c = 1'b0;
    for (int k = 0; k <= 32; k++) hist[k] = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      hist[k] = (((k - 1) / 2) % 2) == 0;
      raw2    = {hist[k], 3'b000};
      tick();
      exp_c = (k >= 4) ? hist[k-3] : 1'b0;
      check($sformatf("p2_k%0d_clean", k), clean2, {exp_c, 3'b000});
      check($sformatf("p2_k%0d_change", k), change2, {exp_c != prev_c, 3'b000});
      check($sformatf("p2_k%0d_any", k), any_change2, exp_c != prev_c);
      if (change2[3]) pulses++;
      prev_c = exp_c;
    end
    check("p2_pulses", pulses, 11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_in4_debounce
